// File: rtl/ex_pkg.sv
// Shared types for the SimpleRISC execute stage: opcode encoding, FSM states, default widths.
package ex_pkg;

  localparam int XLEN_DEF = 32;
  localparam int PC_W_DEF = 10;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_MOD  = 5'd4,
    OP_CMP  = 5'd5,
    OP_AND  = 5'd6,
    OP_OR   = 5'd7,
    OP_NOT  = 5'd8,
    OP_MOV  = 5'd9,
    OP_LSL  = 5'd10,
    OP_LSR  = 5'd11,
    OP_ASR  = 5'd12,
    OP_NOP  = 5'd13,
    OP_LD   = 5'd14,
    OP_ST   = 5'd15,
    OP_BEQ  = 5'd16,
    OP_BGT  = 5'd17,
    OP_B    = 5'd18,
    OP_CALL = 5'd19,
    OP_RET  = 5'd20
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ex_stage_iter_divider.sv
// Signed radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// signs and the div-by-zero / MIN_INT÷-1 corner cases applied at the output.
module iter_divider #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(ITERS + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  always_comb begin
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    dividend_d = dividend_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    div0_d     = div0_q;
    ovf_d      = ovf_q;
    shifted    = {rem_q, quo_q[XLEN-1]};
    trial      = shifted - {1'b0, dvsr_q};
    if (start_i) begin
      cnt_d      = CW'(ITERS);
      rem_d      = '0;
      quo_d      = dividend_i[XLEN-1] ? -dividend_i : dividend_i;
      dvsr_d     = divisor_i[XLEN-1] ? -divisor_i : divisor_i;
      dividend_d = dividend_i;
      neg_q_d    = dividend_i[XLEN-1] ^ divisor_i[XLEN-1];
      neg_r_d    = dividend_i[XLEN-1];
      div0_d     = (divisor_i == '0);
      ovf_d      = (dividend_i == MIN_INT) && (divisor_i == '1);
    end else if (cnt_q != '0) begin
      // Restore by keeping the shifted value when the trial subtraction borrows.
      if (!trial[XLEN]) begin
        rem_d = trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      dividend_q <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div0_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      dividend_q <= dividend_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      div0_q     <= div0_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  // High during the final iteration: results are valid after the coming edge.
  assign done_o = (cnt_q == CW'(1));

  always_comb begin
    if (div0_q) begin
      quotient_o  = '1;
      remainder_o = dividend_q;
    end else if (ovf_q) begin
      quotient_o  = MIN_INT;
      remainder_o = '0;
    end else begin
      quotient_o  = neg_q_q ? -quo_q : quo_q;
      remainder_o = neg_r_q ? -rem_q : rem_q;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// SimpleRISC execute stage: ALU, E/GT flags, branch resolution, iterative div/mod.
// Define ITER_MUL_EN to run mul through the iterative path (shift-add) instead of single-cycle.
//
// state | meaning
// IDLE  | single-cycle ops issue here; div/mod captured and divider started
// DIV   | one iteration per cycle, upstream stalled
// DONE  | iterative result registered toward EX/MA, then back to IDLE
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int PC_W       = PC_W_DEF,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [PC_W-1:0] in_pc,
  input  logic [XLEN-1:0] in_branch_target,
  input  logic [XLEN-1:0] in_op_a,
  input  logic [XLEN-1:0] in_op_b,
  input  logic [XLEN-1:0] in_op2,
  input  logic [XLEN-1:0] in_ir,
  output logic            stall,
  output logic            out_valid,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_ir,
  output logic            is_branch_taken,
  output logic [PC_W-1:0] branch_pc,
  output logic            flag_e,
  output logic            flag_gt
);

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_res_q, out_res_d;
  logic [XLEN-1:0] out_op2_q, out_op2_d;
  logic [XLEN-1:0] out_ir_q, out_ir_d;
  logic            br_taken_q, br_taken_d;
  logic [PC_W-1:0] branch_pc_q, branch_pc_d;
  logic            flag_e_q, flag_e_d;
  logic            flag_gt_q, flag_gt_d;
  logic [PC_W-1:0] cap_pc_q, cap_pc_d;
  logic [XLEN-1:0] cap_op2_q, cap_op2_d;
  logic [XLEN-1:0] cap_ir_q, cap_ir_d;
  logic            cap_mod_q, cap_mod_d;

  opcode_e         op;
  logic [XLEN-1:0] alu_res;
  logic            br_take;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc_plus4;
  logic            is_cmp, iter_op, is_mod_op, is_mul_op;
  logic            iter_fin;
  logic [XLEN-1:0] done_res;
  logic            div_start, div_busy, div_done;
  logic [XLEN-1:0] div_quo, div_rem;
  logic            unused_target_hi;

`ifdef ITER_MUL_EN
  localparam int MCW = $clog2(DIV_CYCLES + 1);
  logic            cap_mul_q, cap_mul_d;
  logic [XLEN-1:0] mul_a_q, mul_a_d;
  logic [XLEN-1:0] mul_b_q, mul_b_d;
  logic [XLEN-1:0] mul_acc_q, mul_acc_d;
  logic [MCW-1:0]  mul_cnt_q, mul_cnt_d;
`endif

  assign op               = opcode_e'(in_ir[31:27]);
  assign pc_plus4         = in_pc + PC_W'(4);
  assign br_target        = (op == OP_RET) ? in_op_a[PC_W-1:0] : in_branch_target[PC_W-1:0];
  assign unused_target_hi = ^in_branch_target[XLEN-1:PC_W];

  // Flags are registered at the cmp's own edge, so a branch one cycle later sees them directly.
  always_comb begin
    alu_res   = '0;
    br_take   = 1'b0;
    is_cmp    = 1'b0;
    iter_op   = 1'b0;
    is_mod_op = 1'b0;
    is_mul_op = 1'b0;
    case (op)
      OP_ADD:  alu_res = in_op_a + in_op_b;
      OP_SUB:  alu_res = in_op_a - in_op_b;
`ifdef ITER_MUL_EN
      OP_MUL: begin
        iter_op   = 1'b1;
        is_mul_op = 1'b1;
      end
`else
      OP_MUL:  alu_res = in_op_a * in_op_b;
`endif
      OP_DIV:  iter_op = 1'b1;
      OP_MOD: begin
        iter_op   = 1'b1;
        is_mod_op = 1'b1;
      end
      OP_CMP:  is_cmp = 1'b1;
      OP_AND:  alu_res = in_op_a & in_op_b;
      OP_OR:   alu_res = in_op_a | in_op_b;
      OP_NOT:  alu_res = ~in_op_b;
      OP_MOV:  alu_res = in_op_b;
      OP_LSL:  alu_res = in_op_a << in_op_b[4:0];
      OP_LSR:  alu_res = in_op_a >> in_op_b[4:0];
      OP_ASR:  alu_res = $signed(in_op_a) >>> in_op_b[4:0];
      OP_LD:   alu_res = in_op_a + in_op_b;
      OP_ST:   alu_res = in_op_a + in_op_b;
      OP_BEQ:  br_take = flag_e_q;
      OP_BGT:  br_take = flag_gt_q;
      OP_B:    br_take = 1'b1;
      OP_CALL: begin
        br_take = 1'b1;
        alu_res = {{(XLEN-PC_W){1'b0}}, pc_plus4};
      end
      OP_RET:  br_take = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    iter_fin = div_done || !div_busy;
    done_res = cap_mod_q ? div_rem : div_quo;
`ifdef ITER_MUL_EN
    if (cap_mul_q) begin
      iter_fin = (mul_cnt_q == MCW'(1));
      done_res = mul_acc_q;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    br_taken_d  = 1'b0;
    out_pc_d    = out_pc_q;
    out_res_d   = out_res_q;
    out_op2_d   = out_op2_q;
    out_ir_d    = out_ir_q;
    branch_pc_d = branch_pc_q;
    flag_e_d    = flag_e_q;
    flag_gt_d   = flag_gt_q;
    cap_pc_d    = cap_pc_q;
    cap_op2_d   = cap_op2_q;
    cap_ir_d    = cap_ir_q;
    cap_mod_d   = cap_mod_q;
    div_start   = 1'b0;
`ifdef ITER_MUL_EN
    cap_mul_d   = cap_mul_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_acc_d   = mul_acc_q;
    mul_cnt_d   = mul_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && iter_op) begin
          state_d   = DIV;
          cap_pc_d  = in_pc;
          cap_op2_d = in_op2;
          cap_ir_d  = in_ir;
          cap_mod_d = is_mod_op;
          div_start = !is_mul_op;
`ifdef ITER_MUL_EN
          cap_mul_d = is_mul_op;
          mul_a_d   = in_op_a;
          mul_b_d   = in_op_b;
          mul_acc_d = '0;
          mul_cnt_d = MCW'(DIV_CYCLES);
`endif
        end else if (in_valid) begin
          out_valid_d = 1'b1;
          out_pc_d    = in_pc;
          out_res_d   = alu_res;
          out_op2_d   = in_op2;
          out_ir_d    = in_ir;
          br_taken_d  = br_take;
          branch_pc_d = br_target;
          if (is_cmp) begin
            flag_e_d  = (in_op_a == in_op_b);
            flag_gt_d = ($signed(in_op_a) > $signed(in_op_b));
          end
        end
      end
      DIV: begin
`ifdef ITER_MUL_EN
        if (cap_mul_q) begin
          if (mul_b_q[0]) mul_acc_d = mul_acc_q + mul_a_q;
          mul_a_d   = mul_a_q << 1;
          mul_b_d   = mul_b_q >> 1;
          mul_cnt_d = mul_cnt_q - MCW'(1);
        end
`endif
        if (iter_fin) state_d = DONE;
      end
      DONE: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_pc_d    = cap_pc_q;
        out_res_d   = done_res;
        out_op2_d   = cap_op2_q;
        out_ir_d    = cap_ir_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_res_q   <= '0;
      out_op2_q   <= '0;
      out_ir_q    <= '0;
      br_taken_q  <= 1'b0;
      branch_pc_q <= '0;
      flag_e_q    <= 1'b0;
      flag_gt_q   <= 1'b0;
      cap_pc_q    <= '0;
      cap_op2_q   <= '0;
      cap_ir_q    <= '0;
      cap_mod_q   <= 1'b0;
`ifdef ITER_MUL_EN
      cap_mul_q   <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_acc_q   <= '0;
      mul_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_res_q   <= out_res_d;
      out_op2_q   <= out_op2_d;
      out_ir_q    <= out_ir_d;
      br_taken_q  <= br_taken_d;
      branch_pc_q <= branch_pc_d;
      flag_e_q    <= flag_e_d;
      flag_gt_q   <= flag_gt_d;
      cap_pc_q    <= cap_pc_d;
      cap_op2_q   <= cap_op2_d;
      cap_ir_q    <= cap_ir_d;
      cap_mod_q   <= cap_mod_d;
`ifdef ITER_MUL_EN
      cap_mul_q   <= cap_mul_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_acc_q   <= mul_acc_d;
      mul_cnt_q   <= mul_cnt_d;
`endif
    end
  end

  iter_divider #(
    .XLEN  (XLEN),
    .ITERS (DIV_CYCLES)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .dividend_i  (in_op_a),
    .divisor_i   (in_op_b),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  assign stall           = (state_q != IDLE);
  assign out_valid       = out_valid_q;
  assign out_pc          = out_pc_q;
  assign out_alu_result  = out_res_q;
  assign out_op2         = out_op2_q;
  assign out_ir          = out_ir_q;
  assign is_branch_taken = br_taken_q;
  assign branch_pc       = branch_pc_q;
  assign flag_e          = flag_e_q;
  assign flag_gt         = flag_gt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage (default build, ITER_MUL_EN undefined).
module tb_ex_stage;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  MUL = 5'd2,  DVD = 5'd3,  MOD = 5'd4;
  localparam logic [4:0] CMP = 5'd5,  NOT = 5'd8,  MOV = 5'd9,  LSL = 5'd10, LSR = 5'd11;
  localparam logic [4:0] ASR = 5'd12, ST  = 5'd15, LD  = 5'd14, BEQ = 5'd16, BGT = 5'd17;
  localparam logic [4:0] CALL = 5'd19, RET = 5'd20, ILL = 5'd25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [9:0]  in_pc;
  logic [31:0] in_branch_target, in_op_a, in_op_b, in_op2, in_ir;
  logic        stall, out_valid, is_branch_taken, flag_e, flag_gt;
  logic [9:0]  out_pc, branch_pc;
  logic [31:0] out_alu_result, out_op2, out_ir;

  int checks   = 0;
  int failures = 0;

  ex_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_pc            (in_pc),
    .in_branch_target (in_branch_target),
    .in_op_a          (in_op_a),
    .in_op_b          (in_op_b),
    .in_op2           (in_op2),
    .in_ir            (in_ir),
    .stall            (stall),
    .out_valid        (out_valid),
    .out_pc           (out_pc),
    .out_alu_result   (out_alu_result),
    .out_op2          (out_op2),
    .out_ir           (out_ir),
    .is_branch_taken  (is_branch_taken),
    .branch_pc        (branch_pc),
    .flag_e           (flag_e),
    .flag_gt          (flag_gt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [9:0] pc, input logic [31:0] tgt);
    in_valid         = 1'b1;
    in_ir            = {op, 27'h0123456};
    in_op_a          = a;
    in_op_b          = b;
    in_pc            = pc;
    in_branch_target = tgt;
    in_op2           = 32'hC0DE0000 | {22'b0, pc};
  endtask

  task automatic exec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [9:0] pc, input logic [31:0] tgt);
    set_in(op, a, b, pc, tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Issue an iterative op, hold a follow-on add upstream, and check stall length and result.
  task automatic run_iter(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int stall_cnt;
    int early_valid;
    stall_cnt   = 0;
    early_valid = 0;
    exec(op, a, b, 10'h30, 32'h0);
    check({tag, "_issue_valid"}, out_valid, 0);
    set_in(ADD, 32'd1, 32'd1, 10'h3C, 32'h0);
    for (int i = 0; i < 60 && stall; i++) begin
      stall_cnt++;
      if (out_valid) early_valid++;
      @(posedge clk);
      #1;
    end
    check({tag, "_stall_cycles"}, stall_cnt, 33);
    check({tag, "_valid_in_stall"}, early_valid, 0);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, out_alu_result, exp);
    check({tag, "_pc"}, out_pc, 10'h30);
    @(posedge clk);
    #1;
    check({tag, "_next_add"}, out_alu_result, 32'd2);
    check({tag, "_next_pc"}, out_pc, 10'h3C);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_branch_target = '0;
    in_op_a = '0; in_op_b = '0; in_op2 = '0; in_ir = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_result", out_alu_result, 0);
    check("rst_flags", {flag_e, flag_gt}, 0);
    check("rst_taken", is_branch_taken, 0);
    rst_n = 1'b1;

    exec(ADD, 32'd7, 32'd5, 10'h10, 32'h0);
    check("add_valid", out_valid, 1);
    check("add_result", out_alu_result, 32'd12);
    check("add_stall", stall, 0);
    check("add_pc", out_pc, 10'h10);
    check("add_ir", out_ir, {ADD, 27'h0123456});
    check("add_op2", out_op2, 32'hC0DE0010);

    exec(SUB, 32'd5, 32'd7, 10'h14, 32'h0);
    check("sub_result", out_alu_result, 32'hFFFFFFFE);

    exec(CMP, 32'd3, 32'd3, 10'h18, 32'h0);
    check("cmp_eq_flags", {flag_e, flag_gt}, 2'b10);
    check("cmp_result", out_alu_result, 0);
    exec(BEQ, 32'd0, 32'd0, 10'h1C, 32'h40);
    check("beq_taken", is_branch_taken, 1);
    check("beq_pc", branch_pc, 10'h40);
    bubble();
    check("bubble_valid", out_valid, 0);
    check("bubble_taken", is_branch_taken, 0);
    check("bubble_flags", {flag_e, flag_gt}, 2'b10);

    exec(CMP, 32'hFFFFFFFF, 32'd1, 10'h20, 32'h0);
    check("cmp_neg_flags", {flag_e, flag_gt}, 2'b00);
    exec(BGT, 32'd0, 32'd0, 10'h24, 32'h55);
    check("bgt_not_taken", is_branch_taken, 0);
    exec(CMP, 32'd5, 32'hFFFFFFFE, 10'h28, 32'h0);
    check("cmp_gt_flags", {flag_e, flag_gt}, 2'b01);
    exec(BGT, 32'd0, 32'd0, 10'h2C, 32'h55);
    check("bgt_taken", is_branch_taken, 1);
    check("bgt_pc", branch_pc, 10'h55);
    exec(BEQ, 32'd0, 32'd0, 10'h30, 32'h66);
    check("beq_not_taken", is_branch_taken, 0);

    exec(LSR, 32'h80000000, 32'd4, 10'h0, 32'h0);
    check("lsr", out_alu_result, 32'h08000000);
    exec(ASR, 32'h80000000, 32'd4, 10'h0, 32'h0);
    check("asr", out_alu_result, 32'hF8000000);
    exec(LSL, 32'd1, 32'd33, 10'h0, 32'h0);
    check("lsl_low5", out_alu_result, 32'd2);
    exec(NOT, 32'h12345678, 32'h0, 10'h0, 32'h0);
    check("not", out_alu_result, 32'hFFFFFFFF);
    exec(MOV, 32'h0, 32'h1234, 10'h0, 32'h0);
    check("mov", out_alu_result, 32'h1234);
    exec(LD, 32'h100, 32'h20, 10'h0, 32'h0);
    check("ld_addr", out_alu_result, 32'h120);
    exec(ST, 32'h200, 32'h4, 10'h44, 32'h0);
    check("st_addr", out_alu_result, 32'h204);
    check("st_op2", out_op2, 32'hC0DE0044);
    exec(MUL, 32'hFFFFFFFF, 32'd3, 10'h0, 32'h0);
    check("mul", out_alu_result, 32'hFFFFFFFD);
    check("mul_stall", stall, 0);
    exec(ILL, 32'd9, 32'd9, 10'h0, 32'h99);
    check("ill_result", out_alu_result, 0);
    check("ill_taken", is_branch_taken, 0);
    check("ill_valid", out_valid, 1);

    exec(RET, 32'h1F4, 32'h0, 10'h50, 32'h77);
    check("ret_taken", is_branch_taken, 1);
    check("ret_pc", branch_pc, 10'h1F4);
    exec(CALL, 32'h0, 32'h0, 10'd8, 32'h80);
    check("call_link", out_alu_result, 32'd12);
    check("call_pc", branch_pc, 10'h80);
    check("call_taken", is_branch_taken, 1);

    run_iter("div_neg", DVD, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_iter("mod_neg", MOD, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_iter("div_negb", DVD, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
    run_iter("mod_negb", MOD, 32'd7, 32'hFFFFFFFE, 32'd1);
    run_iter("div_zero", DVD, 32'd100, 32'd0, 32'hFFFFFFFF);
    run_iter("mod_zero", MOD, 32'd100, 32'd0, 32'd100);
    run_iter("div_ovf", DVD, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_iter("mod_ovf", MOD, 32'h80000000, 32'hFFFFFFFF, 32'd0);

    exec(CMP, 32'd4, 32'd4, 10'h0, 32'h0);
    exec(DVD, 32'd1000, 32'd3, 10'h60, 32'h0);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_div_stall", stall, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_stall", stall, 0);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_result", out_alu_result, 0);
    check("rst_mid_flags", {flag_e, flag_gt}, 0);
    check("rst_mid_pc", out_pc, 0);
    rst_n = 1'b1;
    exec(ADD, 32'd7, 32'd5, 10'h70, 32'h0);
    check("post_rst_add", out_alu_result, 32'd12);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_stall", stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
